// File: rtl/arb_pkg.sv
// arb_pkg: arbitration mode enum and index-width helper shared by the arbiter files.
package arb_pkg;
    typedef enum logic {ARB_RR, ARB_FIXED} arb_mode_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: rotated priority search starting at ptr; one-hot grant plus encoded index.
module rr_priority_pick import arb_pkg::*; #(
    parameter int N = 4,
    parameter int SELW = clog2_min1(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] idx
);
    logic [SELW:0] c;
    logic found;

    // One spare bit lets ptr+k exceed N-1 before the compare-and-clear wrap.
    always_comb begin
        grant = '0;
        idx = '0;
        found = 1'b0;
        c = '0;
        for (int k = 0; k < N; k++) begin
            c = {1'b0, ptr} + (SELW+1)'(k);
            c = (c >= (SELW+1)'(N)) ? c - (SELW+1)'(N) : c;
            if (!found && req[c[SELW-1:0]]) begin
                found = 1'b1;
                grant[c[SELW-1:0]] = 1'b1;
                idx = c[SELW-1:0];
            end
        end
    end
endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel valid/ready arbitrating mux with a single registered output stage.
module rr_arb_mux import arb_pkg::*; #(
    parameter int WIDTH = 64,
    parameter int N = 4,
    parameter arb_mode_t MODE = ARB_RR,
    localparam int SELW = clog2_min1(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         in_valid,
    input  logic [WIDTH-1:0]     in_data [N-1:0],
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
);
    logic [SELW-1:0] ptr, ptr_nxt, idx;
    logic [N-1:0] grant;
    logic load_en, xfer;

    assign load_en = !out_valid | out_ready;
    assign xfer = load_en & |in_valid;
    assign in_ready = (load_en & !reset) ? grant : '0;
    assign ptr_nxt = (idx == SELW'(N-1)) ? '0 : idx + 1'b1;

    rr_priority_pick #(.N(N), .SELW(SELW)) u_pick (
        .req(in_valid),
        .ptr((MODE == ARB_FIXED) ? '0 : ptr),
        .grant(grant),
        .idx(idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data <= '0;
            out_sel <= '0;
            ptr <= '0;
        end else begin
            if (load_en)
                out_valid <= |in_valid;
            if (xfer) begin
                out_data <= in_data[idx];
                out_sel <= idx;
                ptr <= ptr_nxt;
            end
        end
    end
endmodule
